// File: rtl/mux_n_pipe.sv
// mux_n_pipe: N-input, WIDTH-bit registered selector with valid/ready handshake
// and a one-entry skid buffer, so in_ready never depends combinationally on
// out_ready. Out-of-range selects yield zero data and a one-cycle sel_err pulse.
module mux_n_pipe #(
    parameter int unsigned WIDTH  = 5,
    parameter int unsigned NUM_IN = 2,
    parameter int unsigned SEL_W  = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]        sel,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    input  logic                    flush,
    output logic                    sel_err
);

    // Parameter legality: input count range and select wide enough to index it
    generate
        if (NUM_IN < 2 || NUM_IN > 16 || (2 ** SEL_W) < NUM_IN) begin : g_bad_params
            $error("mux_n_pipe: illegal NUM_IN/SEL_W combination");
        end
    endgenerate

    // State bits are {out_valid, skid_valid}
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b10,
        ST_FULL  = 2'b11
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic               in_ready_q;
    logic               sel_err_q;
    logic [WIDTH-1:0]   out_data_q;
    logic [WIDTH-1:0]   skid_data_q;

    logic [WIDTH-1:0]   sel_data_c;
    logic               sel_hit_c;
    logic               accept_c;
    logic               load_out_c;
    logic               load_skid_c;
    logic               skid_to_out_c;

    // Select decode; only looks at sel while in_valid is high, misses give zero
    always_comb begin
        sel_data_c = '0;
        sel_hit_c  = 1'b0;
        if (in_valid) begin
            for (int unsigned k = 0; k < NUM_IN; k++) begin
                if (sel == SEL_W'(k)) begin
                    sel_data_c = in_data[k*WIDTH +: WIDTH];
                    sel_hit_c  = 1'b1;
                end
            end
        end
    end

    assign accept_c = in_valid & in_ready_q;

    // Next-state and datapath load enables; flush overrides everything
    always_comb begin
        state_d       = state_q;
        load_out_c    = 1'b0;
        load_skid_c   = 1'b0;
        skid_to_out_c = 1'b0;
        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept_c) begin
                        state_d    = ST_ONE;
                        load_out_c = 1'b1;
                    end
                end
                ST_ONE: begin
                    if (accept_c && out_ready) begin
                        load_out_c = 1'b1;
                    end else if (accept_c) begin
                        state_d     = ST_FULL;
                        load_skid_c = 1'b1;
                    end else if (out_ready) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (out_ready) begin
                        state_d       = ST_ONE;
                        skid_to_out_c = 1'b1;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                end
            endcase
        end
    end

    // State register plus registered ready; ready drops only when skid fills
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_EMPTY;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            in_ready_q <= (state_d != ST_FULL);
        end
    end

    // Output and skid data registers; untouched unless explicitly loaded
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data_q  <= '0;
            skid_data_q <= '0;
        end else begin
            if (load_out_c) begin
                out_data_q <= sel_data_c;
            end else if (skid_to_out_c) begin
                out_data_q <= skid_data_q;
            end
            if (load_skid_c) begin
                skid_data_q <= sel_data_c;
            end
        end
    end

    // Illegal-select pulse for entries actually kept (not dropped by flush)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_err_q <= 1'b0;
        end else begin
            sel_err_q <= accept_c & ~flush & ~sel_hit_c;
        end
    end

    assign out_valid = state_q[1];
    assign in_ready  = in_ready_q;
    assign out_data  = out_data_q;
    assign sel_err   = sel_err_q;

endmodule

// File: tb/tb_mux_n_pipe.sv
// Bench for mux_n_pipe: two instances (4 inputs and 3 inputs, 5-bit, 2-bit
// select) share stimulus; each is checked every cycle against a two-slot FIFO
// model, plus hand-computed expectations for the directed scenarios.
module tb_mux_n_pipe;

    logic        clk;
    logic        rst_n;
    logic [19:0] in_data;
    logic [1:0]  sel;
    logic        in_valid;
    logic        out_ready;
    logic        flush;

    logic        in_ready4, out_valid4, sel_err4;
    logic [4:0]  out_data4;
    logic        in_ready3, out_valid3, sel_err3;
    logic [4:0]  out_data3;

    int total = 0;
    int bad   = 0;
    bit chk_en = 0;

    // Model: per instance, list of held entries (0..2), last shown value, error pulse
    int         m_cnt  [2];
    logic [4:0] m_buf  [2][2];
    logic [4:0] m_last [2];
    bit         m_err  [2];

    mux_n_pipe #(.WIDTH(5), .NUM_IN(4), .SEL_W(2)) u4 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .sel(sel),
        .in_valid(in_valid), .in_ready(in_ready4), .out_data(out_data4),
        .out_valid(out_valid4), .out_ready(out_ready), .flush(flush),
        .sel_err(sel_err4)
    );

    mux_n_pipe #(.WIDTH(5), .NUM_IN(3), .SEL_W(2)) u3 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data[14:0]), .sel(sel),
        .in_valid(in_valid), .in_ready(in_ready3), .out_data(out_data3),
        .out_valid(out_valid3), .out_ready(out_ready), .flush(flush),
        .sel_err(sel_err3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: FIFO of depth 2 (output + skid), updated at each edge
    always @(posedge clk or negedge rst_n) begin
        int          n;
        bit          rdy;
        bit          acc;
        logic [19:0] shifted;
        logic [4:0]  v;
        if (!rst_n) begin
            for (int m = 0; m < 2; m++) begin
                m_cnt[m]  = 0;
                m_last[m] = 5'd0;
                m_err[m]  = 1'b0;
                m_buf[m][0] = 5'd0;
                m_buf[m][1] = 5'd0;
            end
        end else begin
            for (int m = 0; m < 2; m++) begin
                n   = (m == 0) ? 4 : 3;
                rdy = (m_cnt[m] < 2);
                if (flush) begin
                    m_cnt[m] = 0;
                    m_err[m] = 1'b0;
                end else begin
                    acc     = in_valid && rdy;
                    shifted = in_data >> (int'(sel) * 5);
                    v       = (int'(sel) < n) ? shifted[4:0] : 5'd0;
                    m_err[m] = acc && (int'(sel) >= n);
                    if (m_cnt[m] > 0 && out_ready) begin
                        m_buf[m][0] = m_buf[m][1];
                        m_cnt[m]    = m_cnt[m] - 1;
                    end
                    if (acc) begin
                        m_buf[m][m_cnt[m]] = v;
                        m_cnt[m]           = m_cnt[m] + 1;
                    end
                end
                if (m_cnt[m] > 0) m_last[m] = m_buf[m][0];
            end
        end
    end

    // Compare process: every falling edge, both instances against the model
    always @(negedge clk) begin
        if (chk_en) begin
            chk("u4_out_valid", 32'(out_valid4), 32'(m_cnt[0] > 0));
            chk("u4_in_ready",  32'(in_ready4),  32'(m_cnt[0] < 2));
            chk("u4_out_data",  32'(out_data4),  32'(m_last[0]));
            chk("u4_sel_err",   32'(sel_err4),   32'(m_err[0]));
            chk("u3_out_valid", 32'(out_valid3), 32'(m_cnt[1] > 0));
            chk("u3_in_ready",  32'(in_ready3),  32'(m_cnt[1] < 2));
            chk("u3_out_data",  32'(out_data3),  32'(m_last[1]));
            chk("u3_sel_err",   32'(sel_err3),   32'(m_err[1]));
        end
    end

    // Advance one clock; inputs change 2 time units after the rising edge
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input bit v, input logic [1:0] s, input bit r, input bit f);
        in_valid  = v;
        sel       = s;
        out_ready = r;
        flush     = f;
    endtask

    initial begin
        rst_n = 1'b0;
        in_data = 20'd0;
        drive(1'b0, 2'd0, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #2;
        chk_en = 1'b1;
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid4), 32'd0);
        chk("rst_in_ready",  32'(in_ready4),  32'd1);
        chk("rst_out_data",  32'(out_data4),  32'd0);
        chk("rst_sel_err",   32'(sel_err4),   32'd0);
        cyc();
        rst_n = 1'b1;

        // Single transfer: sel=2 picks 2, gone one cycle later
        in_data = {5'd3, 5'd2, 5'd1, 5'd0};
        drive(1'b1, 2'd2, 1'b1, 1'b0);
        cyc();
        drive(1'b0, 2'd0, 1'b1, 1'b0);
        @(negedge clk);
        chk("t1_out_valid", 32'(out_valid4), 32'd1);
        chk("t1_out_data",  32'(out_data4),  32'd2);
        chk("t1_sel_err",   32'(sel_err4),   32'd0);
        cyc();
        @(negedge clk);
        chk("t1_drain", 32'(out_valid4), 32'd0);

        // Backpressure: 1 then 3 held, third offer refused, then ordered drain
        cyc();
        drive(1'b1, 2'd1, 1'b0, 1'b0);
        cyc();
        drive(1'b1, 2'd3, 1'b0, 1'b0);
        cyc();
        @(negedge clk);
        chk("bp_hold_data", 32'(out_data4), 32'd1);
        chk("bp_in_ready",  32'(in_ready4), 32'd0);
        drive(1'b1, 2'd0, 1'b0, 1'b0);
        cyc();
        @(negedge clk);
        chk("bp_still_data", 32'(out_data4), 32'd1);
        drive(1'b0, 2'd0, 1'b1, 1'b0);
        cyc();
        @(negedge clk);
        chk("bp_second", 32'(out_data4), 32'd3);
        chk("bp_second_valid", 32'(out_valid4), 32'd1);
        cyc();
        @(negedge clk);
        chk("bp_empty", 32'(out_valid4), 32'd0);

        // Streaming with sel cycling 0..3
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 2'(i % 4), 1'b1, 1'b0);
            cyc();
            @(negedge clk);
            chk("stream_data",  32'(out_data4), 32'(i % 4));
            chk("stream_ready", 32'(in_ready4), 32'd1);
        end
        drive(1'b0, 2'd0, 1'b1, 1'b0);
        cyc();

        // Illegal select on the 3-input instance
        drive(1'b1, 2'd3, 1'b1, 1'b0);
        cyc();
        drive(1'b0, 2'd0, 1'b1, 1'b0);
        @(negedge clk);
        chk("ill_data",    32'(out_data3),  32'd0);
        chk("ill_err",     32'(sel_err3),   32'd1);
        chk("ill_valid",   32'(out_valid3), 32'd1);
        chk("legal_err4",  32'(sel_err4),   32'd0);
        cyc();
        @(negedge clk);
        chk("ill_err_gone", 32'(sel_err3), 32'd0);

        // Flush in FULL together with an offered input
        drive(1'b1, 2'd1, 1'b0, 1'b0);
        cyc();
        drive(1'b1, 2'd2, 1'b0, 1'b0);
        cyc();
        drive(1'b1, 2'd0, 1'b1, 1'b1);
        cyc();
        drive(1'b0, 2'd0, 1'b1, 1'b0);
        @(negedge clk);
        chk("fl_valid", 32'(out_valid4), 32'd0);
        chk("fl_ready", 32'(in_ready4),  32'd1);
        cyc();
        @(negedge clk);
        chk("fl_absent", 32'(out_valid4), 32'd0);

        // Async reset mid-cycle while FULL
        in_data = {5'd7, 5'd6, 5'd5, 5'd4};
        drive(1'b1, 2'd1, 1'b0, 1'b0);
        cyc();
        drive(1'b1, 2'd3, 1'b0, 1'b0);
        cyc();
        drive(1'b0, 2'd0, 1'b0, 1'b0);
        chk("pre_rst_full", 32'(in_ready4), 32'd0);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(out_valid4), 32'd0);
        chk("arst_ready", 32'(in_ready4),  32'd1);
        chk("arst_data",  32'(out_data4),  32'd0);
        cyc();
        rst_n = 1'b1;

        // Random traffic, with occasional flush and mid-cycle reset
        for (int i = 0; i < 3000; i++) begin
            in_data = 20'($urandom);
            drive(1'($urandom_range(0, 9) < 7), 2'($urandom_range(0, 3)),
                  1'($urandom_range(0, 9) < 6), 1'($urandom_range(0, 19) == 0));
            cyc();
            if ($urandom_range(0, 299) == 0) begin
                #1 rst_n = 1'b0;
                cyc();
                rst_n = 1'b1;
            end
        end

        drive(1'b0, 2'd0, 1'b1, 1'b0);
        repeat (3) cyc();
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mux_n_pipe.md
Name: mux_n_pipe

Overview:
- Parametrised N-input, WIDTH-bit selector with a registered output stage and a valid/ready handshake.
- Generalises the 2:1 5-bit destination-register select to any input count and width.
- Adds a one-entry skid buffer so the select stage can sit between pipeline stages without a combinational ready path.
- Intended use: register-destination, forwarding and writeback selection in the MIPS datapath, where stall and flush must be honoured.

Parameters:
WIDTH, 5, bit width of each data input and the output
NUM_IN, 2, number of selectable inputs; legal range 2..16
SEL_W, 1, select width; must satisfy 2^SEL_W >= NUM_IN; checked by elaboration-time assertion

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_data  input  NUM_IN*WIDTH  concatenated inputs; input k occupies bits [k*WIDTH +: WIDTH]
sel  input  SEL_W  input index, sampled with in_valid
in_valid  input  1  upstream presents in_data/sel
in_ready  output  1  block can accept this cycle
out_data  output  WIDTH  registered selected value
out_valid  output  1  out_data is valid
out_ready  input  1  downstream accepts out_data this cycle
flush  input  1  synchronous discard of all held entries
sel_err  output  1  registered one-cycle pulse: an accepted sel was >= NUM_IN

Behaviour:
- Clocking and reset:
  - Single clock domain.
  - Reset is asynchronous and active-low (rst_n), applied on assertion and released synchronously to clk.
  - During and after reset: out_valid=0, out_data=0, skid empty (skid data=0), sel_err=0, in_ready=1.
- Selection:
  - sel < NUM_IN selects input sel.
  - sel >= NUM_IN selects all-zero data; the entry is still accepted and sel_err pulses high the cycle after acceptance.
- Accept: in_valid & in_ready at a rising edge.
- Handshake rules:
  - in_ready = ~skid_valid. It is a register output, with no combinational path from out_ready.
  - Latency: data accepted at edge N appears on out_data/out_valid after edge N; 1 cycle.
  - Output transfer: out_valid & out_ready at a rising edge.
  - out_data is held stable while out_valid=1 and out_ready=0.
- State (out_valid, skid_valid); EMPTY(0,0), ONE(1,0), FULL(1,1). Transitions at a rising edge:
  - EMPTY + accept -> ONE; output register loaded.
  - ONE + accept + out_ready -> ONE; output register reloaded with the new value.
  - ONE + accept + !out_ready -> FULL; new value goes to skid.
  - ONE + !accept + out_ready -> EMPTY.
  - FULL + out_ready -> ONE; skid moves to output. No accept is possible because in_ready=0.
  - FULL + !out_ready -> FULL; hold.
- Ordering: strict FIFO. The skid entry is never overtaken.
- Flush:
  - Synchronous. Clears out_valid and skid_valid, so the next state is EMPTY.
  - Has priority over a simultaneous accept (the input is dropped) and over a simultaneous output transfer.
  - sel_err is not raised for a dropped input.
  - Data registers need not clear on flush.
- Throughput: 1 transfer per cycle sustained when out_ready is held high.
- No X propagation: sel is only decoded when in_valid=1; out_data must not change while out_valid=0, except on a load.
- Reset asserted mid-operation: all state clears immediately and asynchronously; in-flight entries are lost.

Test Plan:
- Reset, then NUM_IN=4, WIDTH=5, in_data={5'd3,5'd2,5'd1,5'd0}, sel=2, in_valid=1, out_ready=1 for one cycle -> next cycle out_valid=1, out_data=5'd2, sel_err=0; one cycle later out_valid=0.
- Backpressure: out_ready=0, send sel=1 then sel=3 on consecutive cycles -> out_data=1 held, in_ready=0 after the second accept, third in_valid is not accepted. Raise out_ready -> out_data=1 transfers, then 3, then out_valid=0; no loss or reorder.
- Streaming: out_ready=1, in_valid=1 for 8 cycles with sel cycling 0..3 -> out_data follows 0,1,2,3,0,1,2,3 with 1-cycle lag, in_ready constantly 1.
- Illegal select: NUM_IN=3, SEL_W=2, sel=3 accepted -> out_data=0, sel_err=1 for exactly one cycle.
- Flush in FULL state, with flush and in_valid asserted together -> next cycle out_valid=0, in_ready=1, and the flushed-cycle input is absent from the output.
- Async reset: drop rst_n mid-cycle while in FULL -> out_valid=0 and in_ready=1 before the next clock edge.
